// File: rtl/sx1255_spi_ctrl.sv
// SPI mode-0 master for the SX1255 configuration port: one 16-bit
// {wnr, addr, data} frame per accepted command, last MISO byte returned.
module sx1255_spi_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic       s00_axi_aclk,
  input  logic       s00_axi_reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_wnr,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       spi_sclk,
  output logic       spi_csn,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_B   = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_bit;
  logic [15:0]      r_frame;
  logic [7:0]       r_shift;
  logic             r_sclk;
  logic             r_csn;
  logic             r_mosi;
  logic             r_rsp_valid;
  logic [7:0]       r_rsp_rdata;

  logic [CNT_W-1:0] w_cnt_nx;
  logic [3:0]       w_bit_nx;

  assign w_cnt_nx = r_cnt + CNT_W'(1);
  assign w_bit_nx = r_bit + 4'd1;

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_sclk      <= 1'b0;
      r_csn       <= 1'b1;
      r_mosi      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_frame <= {cmd_wnr, cmd_addr, cmd_wnr ? cmd_wdata : 8'h00};
            r_mosi  <= cmd_wnr;
            r_csn   <= 1'b0;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          if (r_cnt == SETUP_LAST) begin
            r_cnt   <= '0;
            r_state <= SHIFT;
          end else begin
            r_cnt <= w_cnt_nx;
          end
        end
        SHIFT: begin
          // r_bit counts frame bits sent so far; MOSI index is 15 - r_bit.
          if (r_cnt == DIV_LAST) begin
            r_cnt <= '0;
            if (!r_sclk) begin
              r_sclk  <= 1'b1;
              r_shift <= {r_shift[6:0], spi_miso};
            end else begin
              r_sclk <= 1'b0;
              r_bit  <= w_bit_nx;
              if (r_bit == 4'd15) begin
                r_state <= HOLD;
              end else begin
                r_mosi <= r_frame[~w_bit_nx];
              end
            end
          end else begin
            r_cnt <= w_cnt_nx;
          end
        end
        HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_cnt       <= '0;
            r_csn       <= 1'b1;
            r_mosi      <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_shift;
            r_state     <= GAP;
          end else begin
            r_cnt <= w_cnt_nx;
          end
        end
        GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= w_cnt_nx;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == IDLE) && !s00_axi_reset;
  assign busy      = (r_state != IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign spi_sclk  = r_sclk;
  assign spi_csn   = r_csn;
  assign spi_mosi  = r_mosi;

endmodule

// File: tb/tb_sx1255_spi_ctrl.sv
// Bench for sx1255_spi_ctrl: default-timing and minimum-timing instances,
// each driven against a bus-level SPI slave and a frame/latency model.
module tb_sx1255_spi_ctrl;

  localparam int D0_DIV = 4, D0_SETUP = 2, D0_HOLD = 2, D0_GAP = 4;
  localparam int D1_DIV = 1, D1_SETUP = 1, D1_HOLD = 1, D1_GAP = 1;

  typedef struct {
    logic        wnr;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  sl;
    logic [15:0] exp_mosi;
    logic [7:0]  exp_rd;
  } vec_t;

  typedef struct {
    logic [15:0] mosi;
    int          nb;
    int          low;
  } frame_t;

  typedef struct {
    int         t;
    logic [7:0] d;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  logic       valid0 = 1'b0, wnr0 = 1'b0, miso0 = 1'b0;
  logic [6:0] addr0 = '0;
  logic [7:0] wdata0 = '0;
  logic       valid1 = 1'b0, wnr1 = 1'b0, miso1 = 1'b0;
  logic [6:0] addr1 = '0;
  logic [7:0] wdata1 = '0;

  logic       ready0, rspv0, busy0, sclk0, csn0, mosi0;
  logic [7:0] rdata0;
  logic       ready1, rspv1, busy1, sclk1, csn1, mosi1;
  logic [7:0] rdata1;

  int n_chk = 0;
  int n_fail = 0;

  frame_t fq0[$], fq1[$];
  rsp_t   rq0[$], rq1[$];
  logic [15:0] scfg[2];
  int minhi[2];
  int idle_bad[2];
  int per_bad[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sx1255_spi_ctrl #(.CLK_DIV(D0_DIV), .CS_SETUP(D0_SETUP), .CS_HOLD(D0_HOLD), .CS_GAP(D0_GAP)) u_dut (
    .s00_axi_aclk(clk), .s00_axi_reset(rst),
    .cmd_valid(valid0), .cmd_ready(ready0), .cmd_wnr(wnr0), .cmd_addr(addr0), .cmd_wdata(wdata0),
    .rsp_valid(rspv0), .rsp_rdata(rdata0), .busy(busy0),
    .spi_sclk(sclk0), .spi_csn(csn0), .spi_mosi(mosi0), .spi_miso(miso0));

  sx1255_spi_ctrl #(.CLK_DIV(D1_DIV), .CS_SETUP(D1_SETUP), .CS_HOLD(D1_HOLD), .CS_GAP(D1_GAP)) u_fast (
    .s00_axi_aclk(clk), .s00_axi_reset(rst),
    .cmd_valid(valid1), .cmd_ready(ready1), .cmd_wnr(wnr1), .cmd_addr(addr1), .cmd_wdata(wdata1),
    .rsp_valid(rspv1), .rsp_rdata(rdata1), .busy(busy1),
    .spi_sclk(sclk1), .spi_csn(csn1), .spi_mosi(mosi1), .spi_miso(miso1));

  function automatic int p_div(int d);   return d != 0 ? D1_DIV : D0_DIV; endfunction
  function automatic int p_gap(int d);   return d != 0 ? D1_GAP : D0_GAP; endfunction
  function automatic int lat(int d);
    return d != 0 ? 1 + D1_SETUP + 32 * D1_DIV + D1_HOLD : 1 + D0_SETUP + 32 * D0_DIV + D0_HOLD;
  endfunction

  function automatic logic f_ready(int d); return d != 0 ? ready1 : ready0; endfunction
  function automatic logic f_rspv(int d);  return d != 0 ? rspv1 : rspv0; endfunction
  function automatic logic f_busy(int d);  return d != 0 ? busy1 : busy0; endfunction
  function automatic logic f_sclk(int d);  return d != 0 ? sclk1 : sclk0; endfunction
  function automatic logic f_csn(int d);   return d != 0 ? csn1 : csn0; endfunction
  function automatic logic f_mosi(int d);  return d != 0 ? mosi1 : mosi0; endfunction
  function automatic logic [7:0] f_rdata(int d); return d != 0 ? rdata1 : rdata0; endfunction

  // Reference: frame word and returned byte from the command fields alone.
  function automatic vec_t mk(logic wnr, logic [6:0] a, logic [7:0] wd, logic [7:0] sl);
    vec_t v;
    v.wnr = wnr; v.addr = a; v.wdata = wd; v.sl = sl;
    v.exp_mosi = wnr ? {1'b1, a, wd} : {1'b0, a, 8'h00};
    v.exp_rd = sl;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input int d, input logic val, input logic wnr, input logic [6:0] a, input logic [7:0] wd);
    if (d == 0) begin valid0 = val; wnr0 = wnr; addr0 = a; wdata0 = wd; end
    else begin valid1 = val; wnr1 = wnr; addr1 = a; wdata1 = wd; end
  endtask

  function automatic int rq_size(int d); return d != 0 ? rq1.size() : rq0.size(); endfunction
  function automatic int fq_size(int d); return d != 0 ? fq1.size() : fq0.size(); endfunction

  task automatic flush(input int d);
    if (d == 0) begin fq0.delete(); rq0.delete(); end
    else begin fq1.delete(); rq1.delete(); end
  endtask

  task automatic wait_ready(input int d, input int limit);
    int w = 0;
    while (!f_ready(d) && w < limit) begin @(negedge clk); w++; end
  endtask

  // Slave: loads its reply on csn fall, shifts MISO on sclk fall, logs MOSI on sclk rise.
  initial begin : slave_mon
    logic [15:0] mw[2], sw[2];
    int lowc[2], hic[2], nb[2], last_rise[2];
    logic pcsn[2], psclk[2], seen[2];
    frame_t fr;
    rsp_t rr;
    for (int d = 0; d < 2; d++) begin
      mw[d] = '0; sw[d] = '0; lowc[d] = 0; hic[d] = 0; nb[d] = 0; last_rise[d] = 0;
      pcsn[d] = 1'b1; psclk[d] = 1'b0; seen[d] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        logic c, s;
        c = f_csn(d);
        s = f_sclk(d);
        if (c && s) idle_bad[d]++;
        if (!c) begin
          if (pcsn[d]) begin
            if (seen[d] && hic[d] < minhi[d]) minhi[d] = hic[d];
            lowc[d] = 0; nb[d] = 0; mw[d] = '0; sw[d] = scfg[d];
            if (d == 0) miso0 = sw[d][15]; else miso1 = sw[d][15];
          end
          lowc[d]++;
          if (s && !psclk[d]) begin
            mw[d] = {mw[d][14:0], f_mosi(d)};
            if (nb[d] > 0 && cyc - last_rise[d] != 2 * p_div(d)) per_bad[d]++;
            last_rise[d] = cyc;
            nb[d]++;
          end
          if (!s && psclk[d]) begin
            sw[d] = sw[d] << 1;
            if (d == 0) miso0 = sw[d][15]; else miso1 = sw[d][15];
          end
        end else begin
          if (!pcsn[d]) begin
            fr.mosi = mw[d]; fr.nb = nb[d]; fr.low = lowc[d];
            if (d == 0) fq0.push_back(fr); else fq1.push_back(fr);
            seen[d] = 1'b1;
            hic[d] = 0;
          end
          hic[d]++;
        end
        if (f_rspv(d)) begin
          rr.t = cyc; rr.d = f_rdata(d);
          if (d == 0) rq0.push_back(rr); else rq1.push_back(rr);
        end
        pcsn[d] = c;
        psclk[d] = s;
      end
    end
  end

  task automatic send(input int d, input vec_t v, input string tag);
    int t0, w;
    frame_t f;
    rsp_t r;
    scfg[d] = {~v.sl, v.sl};
    wait_ready(d, 400);
    if (!f_ready(d)) begin chk({tag, "_ready_timeout"}, 0, 1); return; end
    drive(d, 1'b1, v.wnr, v.addr, v.wdata);
    t0 = cyc;
    @(negedge clk);
    drive(d, 1'b0, ~v.wnr, ~v.addr, ~v.wdata);
    w = 0;
    while (rq_size(d) == 0 && w < lat(d) + 50) begin @(negedge clk); w++; end
    chk({tag, "_rsp_seen"}, int'(rq_size(d) > 0), 1);
    if (rq_size(d) == 0) return;
    if (d == 0) r = rq0.pop_front(); else r = rq1.pop_front();
    chk({tag, "_rsp_time"}, r.t, t0 + lat(d));
    if (!v.wnr) chk({tag, "_rdata"}, int'(r.d), int'(v.exp_rd));
    wait_ready(d, 200);
    chk({tag, "_next_ready"}, cyc, t0 + lat(d) + p_gap(d));
    if (!v.wnr) chk({tag, "_rdata_hold"}, int'(f_rdata(d)), int'(v.exp_rd));
    @(negedge clk);
    chk({tag, "_rsp_once"}, rq_size(d), 0);
    chk({tag, "_frames"}, fq_size(d), 1);
    if (fq_size(d) == 0) return;
    if (d == 0) f = fq0.pop_front(); else f = fq1.pop_front();
    chk({tag, "_mosi"}, int'(f.mosi), int'(v.exp_mosi));
    chk({tag, "_nbits"}, f.nb, 16);
    chk({tag, "_csn_low"}, f.low, lat(d) - 1);
  endtask

  initial begin : stim
    vec_t tbl[$];
    vec_t ftbl[$];
    int t0, t1, t_abort, w;
    rsp_t r;

    for (int d = 0; d < 2; d++) begin
      scfg[d] = '0; minhi[d] = 1000; idle_bad[d] = 0; per_bad[d] = 0;
    end

    tbl.push_back('{1'b1, 7'h00, 8'hA5, 8'h00, 16'h80A5, 8'h00});
    tbl.push_back('{1'b0, 7'h07, 8'hEE, 8'h3C, 16'h0700, 8'h3C});
    tbl.push_back('{1'b0, 7'h7F, 8'h00, 8'hFF, 16'h7F00, 8'hFF});
    tbl.push_back('{1'b1, 7'h55, 8'h01, 8'h81, 16'hD501, 8'h81});
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom)));
    ftbl.push_back('{1'b1, 7'h7F, 8'hFF, 8'h00, 16'hFFFF, 8'h00});
    for (int i = 0; i < 3; i++)
      ftbl.push_back(mk(1'b0, 7'($urandom), 8'($urandom), 8'($urandom)));

    // Reset state
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_csn", int'(f_csn(d)), 1);
      chk("rst_sclk", int'(f_sclk(d)), 0);
      chk("rst_mosi", int'(f_mosi(d)), 0);
      chk("rst_rspv", int'(f_rspv(d)), 0);
      chk("rst_rdata", int'(f_rdata(d)), 0);
      chk("rst_busy", int'(f_busy(d)), 0);
      chk("rst_ready_low", int'(f_ready(d)), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("post_rst_ready", int'(f_ready(d)), 1);

    foreach (tbl[i]) send(0, tbl[i], $sformatf("d0v%0d", i));
    foreach (ftbl[i]) send(1, ftbl[i], $sformatf("d1v%0d", i));

    // Back-to-back with cmd_valid held; fields changed while busy.
    flush(0);
    minhi[0] = 1000;
    scfg[0] = 16'h00C7;
    wait_ready(0, 400);
    drive(0, 1'b1, 1'b1, 7'h21, 8'h5C);
    t0 = cyc;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 7'h33, 8'h99);
    chk("b2b_ready_busy", int'(ready0), 0);
    chk("b2b_busy", int'(busy0), 1);
    w = 0;
    do begin @(negedge clk); w++; end while (!ready0 && w < 300);
    t1 = cyc;
    chk("b2b_second_accept", t1 - t0, 137);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 7'h00, 8'h00);
    w = 0;
    while ((fq0.size() < 2 || rq0.size() < 2) && w < 300) begin @(negedge clk); w++; end
    chk("b2b_frames", fq0.size(), 2);
    chk("b2b_rsps", rq0.size(), 2);
    if (fq0.size() == 2) begin
      chk("b2b_mosi_a", int'(fq0[0].mosi), int'(16'hA15C));
      chk("b2b_mosi_b", int'(fq0[1].mosi), int'(16'h3300));
    end
    if (rq0.size() == 2) begin
      chk("b2b_rsp_b_time", rq0[1].t, t1 + lat(0));
      chk("b2b_rsp_b_rdata", int'(rq0[1].d), int'(8'hC7));
    end
    chk("b2b_gap_ge_min", int'(minhi[0] >= D0_GAP), 1);

    // Reset during the high phase of bit 8.
    wait_ready(0, 400);
    flush(0);
    scfg[0] = 16'hFFFF;
    drive(0, 1'b1, 1'b1, 7'h6B, 8'h0F);
    t0 = cyc;
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 7'h00, 8'h00);
    t_abort = t0 + 1 + D0_SETUP + 7 * 2 * D0_DIV + D0_DIV + 1;
    while (cyc < t_abort) @(negedge clk);
    chk("abort_sclk_high_before", int'(sclk0), 1);
    chk("abort_csn_low_before", int'(csn0), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_csn", int'(csn0), 1);
    chk("abort_sclk", int'(sclk0), 0);
    chk("abort_busy", int'(busy0), 0);
    chk("abort_rspv", int'(rspv0), 0);
    chk("abort_mosi", int'(mosi0), 0);
    chk("abort_rdata_clr", int'(rdata0), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_no_gap", int'(ready0), 1);
    @(negedge clk);
    chk("abort_no_rsp", rq0.size(), 0);
    flush(0);
    send(0, '{1'b1, 7'h12, 8'h34, 8'h00, 16'h9234, 8'h00}, "after_abort");

    chk("d0_sclk_idle_low", idle_bad[0], 0);
    chk("d1_sclk_idle_low", idle_bad[1], 0);
    chk("d0_sclk_period", per_bad[0], 0);
    chk("d1_sclk_period", per_bad[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #(10 * 60000);
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
